// File: rtl/ex_wb_stage_pkg.sv
// Shared widths, state encoding and write-enable constants for the EX->WB stage.
package ex_wb_stage_pkg;

  localparam int ADDR_WIDTH = 5;
  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ZERO = '0;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

endpackage

// File: rtl/ex_wb_stage_entry_reg.sv
// One buffered result slot (valid + waddr/wdata/we) with load and clear.
module wb_entry_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  load_i,
  input  logic                  clear_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  we_i,
  output logic                  valid_o,
  output logic [ADDR_WIDTH-1:0] waddr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic                  we_o
);
  import ex_wb_stage_pkg::*;

  logic                  r_valid;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_we;

  // Payload is zeroed whenever the slot empties so stale data never leaks out.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || clear_i) begin
      r_valid <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_we    <= WRITE_DISABLE;
    end else if (load_i) begin
      r_valid <= 1'b1;
      r_waddr <= waddr_i;
      r_wdata <= wdata_i;
      r_we    <= we_i;
    end
  end

  assign valid_o = r_valid;
  assign waddr_o = r_waddr;
  assign wdata_o = r_wdata;
  assign we_o    = r_we;

endmodule

// File: rtl/ex_wb_stage.sv
// EX->WB pipeline register with a 2-entry skid buffer, bypass tap and retired-write counter.
//   state    | meaning
//   ST_EMPTY | no result buffered
//   ST_ONE   | head (main) valid, skid empty
//   ST_FULL  | head and skid valid, upstream stalled
module ex_wb_stage #(
  parameter int DATA_WIDTH = ex_wb_stage_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = ex_wb_stage_pkg::ADDR_WIDTH,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  flush_i,
  input  logic                  ex_valid_i,
  output logic                  ex_ready_o,
  input  logic [ADDR_WIDTH-1:0] ex_reg_waddr_i,
  input  logic [DATA_WIDTH-1:0] ex_reg_wdata_i,
  input  logic                  ex_reg_we_i,
  output logic                  wb_valid_o,
  input  logic                  wb_ready_i,
  output logic [ADDR_WIDTH-1:0] wb_reg_waddr_o,
  output logic [DATA_WIDTH-1:0] wb_reg_wdata_o,
  output logic                  wb_reg_we_o,
  output logic                  fwd_valid_o,
  output logic [ADDR_WIDTH-1:0] fwd_waddr_o,
  output logic [DATA_WIDTH-1:0] fwd_wdata_o,
  output logic [CNT_WIDTH-1:0]  retired_cnt_o
);
  import ex_wb_stage_pkg::*;

  state_t                r_state;
  state_t                w_state_next;
  logic [CNT_WIDTH-1:0]  r_retired_cnt;

  logic                  w_main_valid, w_main_we, w_skid_valid, w_skid_we;
  logic [ADDR_WIDTH-1:0] w_main_waddr, w_skid_waddr, w_main_waddr_in;
  logic [DATA_WIDTH-1:0] w_main_wdata, w_skid_wdata, w_main_wdata_in;
  logic                  w_main_we_in;
  logic                  w_main_load, w_main_clr, w_main_from_skid;
  logic                  w_skid_load, w_skid_clr;
  logic                  w_accept, w_retire, w_main_qual, w_skid_qual;

  assign ex_ready_o = !w_skid_valid;
  assign w_accept   = ex_valid_i & ex_ready_o;
  assign w_retire   = wb_valid_o & wb_ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) r_state <= ST_EMPTY;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next     = r_state;
    w_main_load      = 1'b0;
    w_main_clr       = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_load      = 1'b0;
    w_skid_clr       = 1'b0;
    if (flush_i) begin
      w_main_clr   = 1'b1;
      w_skid_clr   = 1'b1;
      w_state_next = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_accept) begin
          w_main_load  = 1'b1;
          w_state_next = ST_ONE;
        end
        ST_ONE: begin
          if (w_accept && w_retire) begin
            w_main_load = 1'b1;
          end else if (w_accept) begin
            w_skid_load  = 1'b1;
            w_state_next = ST_FULL;
          end else if (w_retire) begin
            w_main_clr   = 1'b1;
            w_state_next = ST_EMPTY;
          end
        end
        ST_FULL: if (w_retire) begin
          w_main_load      = 1'b1;
          w_main_from_skid = 1'b1;
          w_skid_clr       = 1'b1;
          w_state_next     = ST_ONE;
        end
        default: w_state_next = ST_EMPTY;
      endcase
    end
  end

  assign w_main_waddr_in = w_main_from_skid ? w_skid_waddr : ex_reg_waddr_i;
  assign w_main_wdata_in = w_main_from_skid ? w_skid_wdata : ex_reg_wdata_i;
  assign w_main_we_in    = w_main_from_skid ? w_skid_we    : ex_reg_we_i;

  wb_entry_reg #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_main (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .load_i(w_main_load), .clear_i(w_main_clr),
    .waddr_i(w_main_waddr_in), .wdata_i(w_main_wdata_in), .we_i(w_main_we_in),
    .valid_o(w_main_valid), .waddr_o(w_main_waddr), .wdata_o(w_main_wdata), .we_o(w_main_we)
  );

  wb_entry_reg #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_skid (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .load_i(w_skid_load), .clear_i(w_skid_clr),
    .waddr_i(ex_reg_waddr_i), .wdata_i(ex_reg_wdata_i), .we_i(ex_reg_we_i),
    .valid_o(w_skid_valid), .waddr_o(w_skid_waddr), .wdata_o(w_skid_wdata), .we_o(w_skid_we)
  );

  // x0 and non-writing results still flow through but never write or bypass.
  assign w_main_qual = w_main_valid & w_main_we & (w_main_waddr != ADDR_WIDTH'(ZERO));
  assign w_skid_qual = w_skid_valid & w_skid_we & (w_skid_waddr != ADDR_WIDTH'(ZERO));

  assign wb_valid_o     = w_main_valid;
  assign wb_reg_we_o    = w_main_qual ? WRITE_ENABLE : WRITE_DISABLE;
  assign wb_reg_waddr_o = w_main_valid ? w_main_waddr : '0;
  assign wb_reg_wdata_o = w_main_valid ? w_main_wdata : '0;

  always_comb begin
    fwd_valid_o = 1'b0;
    fwd_waddr_o = '0;
    fwd_wdata_o = '0;
    if (w_skid_qual) begin
      fwd_valid_o = 1'b1;
      fwd_waddr_o = w_skid_waddr;
      fwd_wdata_o = w_skid_wdata;
    end else if (w_main_qual) begin
      fwd_valid_o = 1'b1;
      fwd_waddr_o = w_main_waddr;
      fwd_wdata_o = w_main_wdata;
    end
  end

  // A retire coinciding with flush still counts: the write port already took it.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i)                    r_retired_cnt <= '0;
    else if (w_retire && wb_reg_we_o) r_retired_cnt <= r_retired_cnt + 1'b1;
  end

  assign retired_cnt_o = r_retired_cnt;

endmodule

// File: tb/tb_ex_wb_stage.sv
// Directed checks of the EX->WB skid stage (4-bit counter instance to exercise wrap).
module tb_ex_wb_stage;
  logic        clk_i = 1'b0;
  logic        rst_n_i, flush_i, ex_valid_i, ex_ready_o, ex_reg_we_i;
  logic [4:0]  ex_reg_waddr_i, wb_reg_waddr_o, fwd_waddr_o;
  logic [31:0] ex_reg_wdata_i, wb_reg_wdata_o, fwd_wdata_o;
  logic        wb_valid_o, wb_ready_i, wb_reg_we_o, fwd_valid_o;
  logic [3:0]  retired_cnt_o;
  int          errors = 0;
  int          checks = 0;

  always #5 clk_i = ~clk_i;

  ex_wb_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(4)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
    .ex_reg_waddr_i(ex_reg_waddr_i), .ex_reg_wdata_i(ex_reg_wdata_i), .ex_reg_we_i(ex_reg_we_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_reg_waddr_o(wb_reg_waddr_o), .wb_reg_wdata_o(wb_reg_wdata_o), .wb_reg_we_o(wb_reg_we_o),
    .fwd_valid_o(fwd_valid_o), .fwd_waddr_o(fwd_waddr_o), .fwd_wdata_o(fwd_wdata_o),
    .retired_cnt_o(retired_cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [4:0] a, input logic [31:0] d, input logic we);
    ex_valid_i     = 1'b1;
    ex_reg_waddr_i = a;
    ex_reg_wdata_i = d;
    ex_reg_we_i    = we;
  endtask

  initial begin
    rst_n_i = 1'b0; flush_i = 1'b0; wb_ready_i = 1'b0;
    send(5'd9, 32'h99, 1'b1);
    tick(); tick();
    rst_n_i = 1'b1; ex_valid_i = 1'b0;
    chk("rst_ex_ready", ex_ready_o, 1);
    chk("rst_wb_valid", wb_valid_o, 0);
    chk("rst_cnt", retired_cnt_o, 0);
    chk("rst_fwd_valid", fwd_valid_o, 0);
    chk("rst_wb_we", wb_reg_we_o, 0);
    chk("rst_wb_waddr", wb_reg_waddr_o, 0);
    chk("rst_wb_wdata", wb_reg_wdata_o, 0);

    // streaming, no back-pressure
    wb_ready_i = 1'b1;
    send(5'd5, 32'h11, 1'b1);
    tick();
    chk("st1_valid", wb_valid_o, 1);
    chk("st1_waddr", wb_reg_waddr_o, 5);
    chk("st1_wdata", wb_reg_wdata_o, 32'h11);
    chk("st1_we", wb_reg_we_o, 1);
    chk("st1_fwd_waddr", fwd_waddr_o, 5);
    send(5'd6, 32'h22, 1'b1);
    tick();
    chk("st2_waddr", wb_reg_waddr_o, 6);
    chk("st2_wdata", wb_reg_wdata_o, 32'h22);
    chk("st2_we", wb_reg_we_o, 1);
    chk("st2_cnt", retired_cnt_o, 1);
    ex_valid_i = 1'b0;
    tick();
    chk("st_drain_valid", wb_valid_o, 0);
    chk("st_drain_waddr", wb_reg_waddr_o, 0);
    chk("st_cnt", retired_cnt_o, 2);

    // back-pressure
    wb_ready_i = 1'b0;
    send(5'd3, 32'hA, 1'b1);
    tick();
    send(5'd4, 32'hB, 1'b1);
    chk("bp_ready_one", ex_ready_o, 1);
    tick();
    chk("bp_ready_full", ex_ready_o, 0);
    chk("bp_head_a", wb_reg_waddr_o, 3);
    chk("bp_fwd_skid_addr", fwd_waddr_o, 4);
    chk("bp_fwd_skid_data", fwd_wdata_o, 32'hB);
    send(5'd8, 32'hC, 1'b1);
    tick();
    chk("bp_hold_ready", ex_ready_o, 0);
    chk("bp_hold_head", wb_reg_wdata_o, 32'hA);
    chk("bp_hold_cnt", retired_cnt_o, 2);
    wb_ready_i = 1'b1;
    chk("bp_no_comb_ready", ex_ready_o, 0);
    tick();
    chk("bp_head_b_addr", wb_reg_waddr_o, 4);
    chk("bp_head_b_data", wb_reg_wdata_o, 32'hB);
    chk("bp_ready_back", ex_ready_o, 1);
    chk("bp_cnt_a", retired_cnt_o, 3);
    tick();
    chk("bp_head_c_addr", wb_reg_waddr_o, 8);
    chk("bp_head_c_data", wb_reg_wdata_o, 32'hC);
    ex_valid_i = 1'b0;
    tick();
    chk("bp_drained", wb_valid_o, 0);
    chk("bp_cnt", retired_cnt_o, 5);

    // x0 and we=0 results occupy a slot but never write
    wb_ready_i = 1'b0;
    send(5'd0, 32'hDEAD, 1'b1);
    tick();
    chk("x0_valid", wb_valid_o, 1);
    chk("x0_we", wb_reg_we_o, 0);
    chk("x0_data", wb_reg_wdata_o, 32'hDEAD);
    chk("x0_fwd", fwd_valid_o, 0);
    ex_valid_i = 1'b0; wb_ready_i = 1'b1;
    tick();
    chk("x0_cnt", retired_cnt_o, 5);
    chk("x0_gone", wb_valid_o, 0);
    send(5'd3, 32'h33, 1'b0);
    tick();
    chk("nowe_we", wb_reg_we_o, 0);
    chk("nowe_fwd", fwd_valid_o, 0);
    ex_valid_i = 1'b0;
    tick();
    chk("nowe_cnt", retired_cnt_o, 5);

    // forwarding priority: younger skid wins
    wb_ready_i = 1'b0;
    send(5'd7, 32'h1, 1'b1);
    tick();
    chk("fwd_main_data", fwd_wdata_o, 32'h1);
    send(5'd7, 32'h2, 1'b1);
    tick();
    chk("fwd_valid", fwd_valid_o, 1);
    chk("fwd_waddr", fwd_waddr_o, 7);
    chk("fwd_wdata", fwd_wdata_o, 32'h2);

    // flush from FULL with simultaneous accept attempt and retire
    flush_i = 1'b1; wb_ready_i = 1'b1;
    send(5'd9, 32'h99, 1'b1);
    tick();
    flush_i = 1'b0; ex_valid_i = 1'b0;
    chk("fl_ready", ex_ready_o, 1);
    chk("fl_valid", wb_valid_o, 0);
    chk("fl_cnt", retired_cnt_o, 6);
    chk("fl_fwd", fwd_valid_o, 0);
    tick();
    chk("fl_dropped", wb_valid_o, 0);

    // reset mid-stream drops entries without retiring
    wb_ready_i = 1'b0;
    send(5'd2, 32'h5, 1'b1);
    tick();
    rst_n_i = 1'b0; wb_ready_i = 1'b1;
    tick();
    rst_n_i = 1'b1; ex_valid_i = 1'b0;
    chk("mrst_valid", wb_valid_o, 0);
    chk("mrst_cnt", retired_cnt_o, 0);

    // 17 real writes wrap the 4-bit counter to 1
    for (int i = 0; i < 17; i++) begin
      send(5'(i % 31 + 1), 32'(i), 1'b1);
      tick();
    end
    ex_valid_i = 1'b0;
    tick();
    chk("wrap_cnt", retired_cnt_o, 1);
    chk("wrap_empty", wb_valid_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ex_wb_stage.md
Name: ex_wb_stage

Overview:
Pipeline register and elastic buffer between the integer execute units and the register-file write port. Captures each execute result (write address, data, write enable) with a valid/ready handshake and presents it in order to the write-back port. Absorbs one cycle of write-port back-pressure through a 2-entry skid buffer. Exposes the youngest pending write for operand forwarding into the operand-select logic.

Parameters:
DATA_WIDTH, 32, width of result data (matches `DATA_WIDTH)
ADDR_WIDTH, 5, register index width
CNT_WIDTH, 32, width of retired-write counter

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_n_i  in  1  synchronous active-low reset
flush_i  in  1  discard all buffered results (branch/trap redirect)
ex_valid_i  in  1  execute result valid
ex_ready_o  out  1  stage can accept a result this cycle
ex_reg_waddr_i  in  ADDR_WIDTH  destination register
ex_reg_wdata_i  in  DATA_WIDTH  result data
ex_reg_we_i  in  1  result writes a register
wb_valid_o  out  1  head entry valid
wb_ready_i  in  1  write port accepts head this cycle
wb_reg_waddr_o  out  ADDR_WIDTH  head destination
wb_reg_wdata_o  out  DATA_WIDTH  head data
wb_reg_we_o  out  1  head write enable (gated, see Behaviour)
fwd_valid_o  out  1  a pending write is available for bypass
fwd_waddr_o  out  ADDR_WIDTH  bypass register index
fwd_wdata_o  out  DATA_WIDTH  bypass data
retired_cnt_o  out  CNT_WIDTH  count of retired real register writes

Behaviour:
- Clock clk_i; reset is synchronous and active-low on rst_n_i, sampled on the rising edge.
- Storage: head entry (main) and tail entry (skid), each {valid, waddr, wdata, we}. States: EMPTY (none valid), ONE (main only), FULL (main+skid).
- Reset (rst_n_i=0 at edge): both entries invalid, retired_cnt_o=0, state EMPTY; ex_ready_o=1, wb_valid_o=0, wb_reg_we_o=0, wb_reg_waddr_o=0, wb_reg_wdata_o=0, fwd_valid_o=0 from the next cycle. Reset overrides flush and handshakes; reset mid-stream drops buffered entries without retiring them.
- ex_ready_o = !skid.valid; registered-state only, with no combinational path from wb_ready_i.
- accept = ex_valid_i & ex_ready_o; retire = wb_valid_o & wb_ready_i.
- EMPTY: accept -> ONE (load main).
- ONE: accept & retire -> ONE (main <= input). Accept only -> FULL (skid <= input). Retire only -> EMPTY.
- FULL: ex_ready_o=0. Retire -> ONE (main <= skid, skid invalid). Otherwise hold.
- Latency: a result accepted at edge N is on wb_* after edge N (1 cycle) when the stage is not back-pressured. Order is strictly preserved.
- wb_reg_we_o = main.valid & main.we & (main.waddr != 0). x0 writes and we=0 results still occupy a slot and retire in order, but never assert write enable.
- wb_reg_waddr_o and wb_reg_wdata_o show main fields when valid and 0 when invalid.
- retired_cnt_o increments by 1 on each retire with wb_reg_we_o=1. It wraps modulo 2^CNT_WIDTH.
- Flush: flush_i=1 at edge invalidates both entries (-> EMPTY). A simultaneous accept is discarded. A simultaneous retire still counts, because the write port already took it.
- Forwarding (combinational from registered state only): priority goes to skid (younger), then main. An entry qualifies if valid & we & waddr!=0. fwd_valid_o=0 and fwd_waddr_o/fwd_wdata_o=0 when no entry qualifies.
- No X propagation: all outputs are driven to defined values in every state.

Decomposition:
- Shared package/defines: ADDR_WIDTH, DATA_WIDTH, the 2-bit state encoding (ST_EMPTY=0, ST_ONE=1, ST_FULL=2), the ZERO constant, and the WRITE_ENABLE/WRITE_DISABLE constants.
- One natural sub-module: wb_entry_reg, a single valid+payload register with load/clear. It is instantiated twice, for main and skid.
- The state machine, handshake, forwarding mux and counter stay in ex_wb_stage.

Test Plan:
- Reset: hold rst_n_i=0 two cycles with ex_valid_i=1 -> after release ex_ready_o=1, wb_valid_o=0, retired_cnt_o=0, fwd_valid_o=0.
- Streaming: wb_ready_i=1, send waddr=5/wdata=0x11, waddr=6/wdata=0x22 on consecutive cycles -> each on wb_* one cycle later in order, wb_reg_we_o=1 both, retired_cnt_o=2.
- Back-pressure: wb_ready_i=0, send A(x3,0xA), B(x4,0xB), C -> ex_ready_o=0 after B, C is held upstream. Raise wb_ready_i -> A, B, C retire in order, no loss or duplicate.
- x0 and forwarding: send x0/0xDEAD with we=1 -> wb_reg_we_o=0, counter unchanged. With main=x7/0x1 and skid=x7/0x2 pending -> fwd_valid_o=1, fwd_wdata_o=0x2.
- Flush: FULL state, assert flush_i with ex_valid_i=1 and wb_ready_i=1 -> next cycle EMPTY, ex_ready_o=1, the head retire is counted, the incoming result is dropped.
- Counter wrap: CNT_WIDTH=4, retire 17 real writes -> retired_cnt_o=1.
